// File: rtl/burst_read_master_fifo.sv
// Avalon-MM bursting read master with a show-ahead read-data FIFO and credit-based issue.
// Optional abort support is compiled in when BRM_ABORT_EN is defined.
`timescale 1ns/1ps
module burst_read_master_fifo #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int MAXBURSTCOUNT   = 8,
  parameter int BURSTCOUNTWIDTH = 4,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
`ifdef BRM_ABORT_EN
  input  logic                       control_abort,
`endif
  output logic                       control_done,
  output logic                       control_busy,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
  input  logic                       master_waitrequest,
  input  logic                       master_readdatavalid,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available
);

  localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
  localparam int MB_LOG2 = $clog2(MAXBURSTCOUNT);
  localparam int PW      = FIFODEPTH_LOG2 + 1;
  localparam int CW      = FIFODEPTH_LOG2 + 2;
  localparam logic [ADDRESSWIDTH-1:0] WORD_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state, state_next;
  logic [ADDRESSWIDTH-1:0]    address, length, words_left;
  logic                       fixed_q, hold_q, abort_q, abort_in, stop;
  logic [PW-1:0]              reads_pending, fifo_used;
  logic [FIFODEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DATAWIDTH-1:0]       mem [FIFODEPTH];
  logic [MB_LOG2-1:0]         off;
  logic [BURSTCOUNTWIDTH-1:0] max_bc, bc;
  logic                       credit_ok, accept, last_cmd, go_ok, push, pop, flushing;

  // Burst sizing: never cross a MAXBURSTCOUNT-word boundary, never exceed what is left.
  assign off        = address[BE_LOG2 +: MB_LOG2];
  assign words_left = length >> BE_LOG2;
  assign max_bc     = BURSTCOUNTWIDTH'(MAXBURSTCOUNT) - BURSTCOUNTWIDTH'(off);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bc = max_bc;
    if (fixed_q)
      bc = BURSTCOUNTWIDTH'(1);
    else if (words_left < ADDRESSWIDTH'(max_bc))
      bc = BURSTCOUNTWIDTH'(words_left);
  end

  assign credit_ok = (CW'(reads_pending) + CW'(fifo_used) + CW'(bc)) <= CW'(FIFODEPTH);
  assign go_ok     = control_go && ((control_read_length >> BE_LOG2) != '0);
  assign accept    = master_read & ~master_waitrequest;
  assign last_cmd  = words_left == ADDRESSWIDTH'(bc);
  assign stop      = abort_in | abort_q;
  assign flushing  = (state == DRAIN) & abort_q;

`ifdef BRM_ABORT_EN
  assign abort_in = control_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      abort_q <= 1'b0;
    else if (state == DRAIN && reads_pending == '0)
      abort_q <= 1'b0;
    else if (state == RUN && control_abort)
      abort_q <= 1'b1;
  end
`else
  assign abort_in = 1'b0;
  assign abort_q  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    master_read = 1'b0;
    case (state)
      IDLE:  if (go_ok) state_next = RUN;
      RUN: begin
        // A stalled command stays asserted until accepted, even under abort.
        master_read = hold_q | (~stop & (words_left != '0) & credit_ok);
        if (accept && last_cmd)
          state_next = DRAIN;
        else if (stop && !(master_read && master_waitrequest))
          state_next = DRAIN;
      end
      DRAIN: if (reads_pending == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address       <= '0;
      length        <= '0;
      fixed_q       <= 1'b0;
      hold_q        <= 1'b0;
      reads_pending <= '0;
    end else begin
      hold_q        <= master_read & master_waitrequest;
      reads_pending <= reads_pending + (accept ? PW'(bc) : PW'(0)) - PW'(master_readdatavalid);
      if (state == IDLE && go_ok) begin
        address <= control_read_base & WORD_MASK;
        length  <= control_read_length & WORD_MASK;
        fixed_q <= control_fixed_location;
      end else if (accept) begin
        if (!fixed_q) address <= address + (ADDRESSWIDTH'(bc) << BE_LOG2);
        length <= length - (ADDRESSWIDTH'(bc) << BE_LOG2);
      end
    end
  end

  // Credit accounting guarantees the FIFO never overflows, so push needs no full check.
  assign push = master_readdatavalid & ~flushing;
  assign pop  = user_read_buffer & user_data_available & ~flushing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
    end else if (flushing) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_used <= fifo_used + PW'(push) - PW'(pop);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers and fifo_used.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= master_readdata;
  end

  assign control_done        = (state == IDLE);
  assign control_busy        = ~control_done;
  assign master_address      = address;
  assign master_byteenable   = '1;
  assign master_burstcount   = bc;
  assign user_buffer_data    = mem[rd_ptr];
  assign user_data_available = (fifo_used != '0);

endmodule

// File: tb/tb_burst_read_master_fifo.sv
// Self-checking bench for burst_read_master_fifo: Avalon slave model with 2-cycle latency,
// user pop agent, and a scoreboard of expected words filled when each transfer is started.
`timescale 1ns/1ps
module tb_burst_read_master_fifo;

  typedef struct {
    int          ready;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bc;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        control_fixed_location;
  logic [31:0] control_read_base;
  logic [31:0] control_read_length;
  logic        control_go;
  logic        control_abort;
  logic        control_done;
  logic        control_busy;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [3:0]  master_burstcount;
  logic        master_waitrequest;
  logic        master_readdatavalid;
  logic [31:0] master_readdata;
  logic        user_read_buffer;
  logic [31:0] user_buffer_data;
  logic        user_data_available;

  int checks   = 0;
  int failures = 0;

  resp_t       resp_q[$];
  cmd_t        cmd_q[$];
  logic [31:0] exp_q[$];
  int          cyc        = 0;
  int          stall_cnt  = 0;
  int          stall_seen = 0;
  int          pop_budget = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr;
  logic [3:0]  prev_bc;

  always #5 clk = ~clk;

  burst_read_master_fifo dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_read_base      (control_read_base),
    .control_read_length    (control_read_length),
    .control_go             (control_go),
`ifdef BRM_ABORT_EN
    .control_abort          (control_abort),
`endif
    .control_done           (control_done),
    .control_busy           (control_busy),
    .master_address         (master_address),
    .master_read            (master_read),
    .master_byteenable      (master_byteenable),
    .master_burstcount      (master_burstcount),
    .master_waitrequest     (master_waitrequest),
    .master_readdatavalid   (master_readdatavalid),
    .master_readdata        (master_readdata),
    .user_read_buffer       (user_read_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_data_available    (user_data_available)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Slave + user agent: acts 1 time unit after each falling edge.
  initial begin
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    user_read_buffer     = 1'b0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (reset) begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        user_read_buffer     = 1'b0;
        prev_stalled         = 1'b0;
      end else begin
        master_waitrequest = (stall_cnt > 0);
        if (prev_stalled) begin
          check("stall_read_held", {31'd0, master_read}, 32'd1);
          check("stall_addr_held", master_address, prev_addr);
          check("stall_bc_held", {28'd0, master_burstcount}, {28'd0, prev_bc});
        end
        prev_stalled = 1'b0;
        if (master_read) begin
          if (master_waitrequest) begin
            stall_cnt--;
            stall_seen++;
            prev_stalled = 1'b1;
            prev_addr    = master_address;
            prev_bc      = master_burstcount;
          end else begin
            cmd_q.push_back('{master_address, master_burstcount});
            for (int i = 0; i < int'(master_burstcount); i++)
              resp_q.push_back('{cyc + 2, mem_word(master_address + 32'(4 * i))});
          end
        end
        if (resp_q.size() > 0 && resp_q[0].ready <= cyc) begin
          master_readdatavalid = 1'b1;
          master_readdata      = resp_q[0].data;
          void'(resp_q.pop_front());
        end else begin
          master_readdatavalid = 1'b0;
        end
        if (pop_budget > 0 && user_data_available) begin
          user_read_buffer = 1'b1;
          pop_budget--;
          if (exp_q.size() > 0) check("pop_data", user_buffer_data, exp_q.pop_front());
          else                  check("pop_expected_words_left", exp_q.size(), 32'd1);
        end else begin
          user_read_buffer = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic start(input logic [31:0] base, input logic [31:0] len, input logic fix, input int nwords);
    for (int i = 0; i < nwords; i++)
      exp_q.push_back(mem_word(fix ? base : base + 32'(4 * i)));
    @(negedge clk);
    control_read_base      = base;
    control_read_length    = len;
    control_fixed_location = fix;
    control_go             = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    check("busy_after_go", {31'd0, control_busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!control_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, control_done}, 32'd1);
  endtask

  task automatic check_cmd(input int idx, input logic [31:0] addr, input logic [3:0] bc);
    if (idx < cmd_q.size()) begin
      check($sformatf("cmd%0d_addr", idx), cmd_q[idx].addr, addr);
      check($sformatf("cmd%0d_bc", idx), {28'd0, cmd_q[idx].bc}, {28'd0, bc});
    end else begin
      check($sformatf("cmd%0d_present", idx), cmd_q.size(), 32'(idx + 1));
    end
  endtask

  initial begin
    int n;
    reset                  = 1'b1;
    control_fixed_location = 1'b0;
    control_read_base      = '0;
    control_read_length    = '0;
    control_go             = 1'b0;
    control_abort          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, control_done}, 32'd1);
    check("rst_busy", {31'd0, control_busy}, 32'd0);
    check("rst_read", {31'd0, master_read}, 32'd0);
    check("rst_avail", {31'd0, user_data_available}, 32'd0);
    check("byteenable", {28'd0, master_byteenable}, 32'hF);
    reset = 1'b0;

    // go with a sub-word length: stays idle
    @(negedge clk);
    control_read_length = 32'd3;
    control_go          = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    repeat (3) @(negedge clk);
    check("zero_len_done", {31'd0, control_done}, 32'd1);
    check("zero_len_cmds", cmd_q.size(), 32'd0);

    // 1: aligned 64 bytes, user pops continuously
    pop_budget = 1000000;
    start(32'h0, 32'd64, 1'b0, 16);
    wait_done(300, "t1");
    repeat (10) @(negedge clk);
    check("t1_cmds", cmd_q.size(), 32'd2);
    check_cmd(0, 32'h00, 4'd8);
    check_cmd(1, 32'h20, 4'd8);
    check("t1_words_left", exp_q.size(), 32'd0);
    check("t1_avail", {31'd0, user_data_available}, 32'd0);

    // 2: unaligned start splits at the burst boundary
    cmd_q.delete();
    start(32'h14, 32'd40, 1'b0, 10);
    wait_done(300, "t2");
    repeat (10) @(negedge clk);
    check("t2_cmds", cmd_q.size(), 32'd2);
    check_cmd(0, 32'h14, 4'd3);
    check_cmd(1, 32'h20, 4'd7);
    check("t2_words_left", exp_q.size(), 32'd0);

    // 3: credit limit with no user pops
    cmd_q.delete();
    pop_budget = 0;
    start(32'h0, 32'd256, 1'b0, 64);
    repeat (60) @(negedge clk);
    check("t3_cmds_at_credit_limit", cmd_q.size(), 32'd4);
    check("t3_read_blocked", {31'd0, master_read}, 32'd0);
    check("t3_avail", {31'd0, user_data_available}, 32'd1);
    pop_budget = 8;
    repeat (20) @(negedge clk);
    check("t3_cmds_after_8_pops", cmd_q.size(), 32'd5);
    check_cmd(4, 32'h80, 4'd8);
    repeat (20) @(negedge clk);
    check("t3_cmds_still_blocked", cmd_q.size(), 32'd5);
    pop_budget = 1000000;
    wait_done(600, "t3");
    repeat (40) @(negedge clk);
    check("t3_cmds_total", cmd_q.size(), 32'd8);
    check("t3_words_left", exp_q.size(), 32'd0);

    // 4: stalled first command, fixed-location mode
    cmd_q.delete();
    stall_seen = 0;
    stall_cnt  = 5;
    start(32'h100, 32'd16, 1'b1, 4);
    wait_done(300, "t4");
    repeat (10) @(negedge clk);
    check("t4_stall_cycles", stall_seen, 32'd5);
    check("t4_cmds", cmd_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_cmd(i, 32'h100, 4'd1);
    check("t4_words_left", exp_q.size(), 32'd0);

`ifdef BRM_ABORT_EN
    // 5: abort after the second burst is accepted
    cmd_q.delete();
    pop_budget = 0;
    start(32'h0, 32'd128, 1'b0, 0);
    n = 0;
    while (cmd_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    control_abort = 1'b1;
    @(negedge clk);
    control_abort = 1'b0;
    wait_done(300, "t5");
    check("t5_cmds", cmd_q.size(), 32'd2);
    check("t5_returns_outstanding", resp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("t5_fifo_empty", {31'd0, user_data_available}, 32'd0);
    check("t5_cmds_after", cmd_q.size(), 32'd2);
`endif

    // 6: reset mid-burst, then a clean transfer
    cmd_q.delete();
    exp_q.delete();
    pop_budget = 1000000;
    start(32'h0, 32'd64, 1'b0, 16);
    n = 0;
    while (cmd_q.size() < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    check("t6_rst_read", {31'd0, master_read}, 32'd0);
    check("t6_rst_done", {31'd0, control_done}, 32'd1);
    check("t6_rst_avail", {31'd0, user_data_available}, 32'd0);
    resp_q.delete();
    exp_q.delete();
    cmd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start(32'h40, 32'd32, 1'b0, 8);
    wait_done(300, "t6");
    repeat (10) @(negedge clk);
    check("t6_cmds", cmd_q.size(), 32'd1);
    check_cmd(0, 32'h40, 4'd8);
    check("t6_words_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
